// File: rtl/zjh_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : zjh_pkg
//  Purpose  : Shared types and encodings for the 74HC194 shift controller.
//  Revision : 1.0 - initial release
// ============================================================================
package zjh_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    // S1:S0 select codes of the 74HC194 stage
    localparam logic [1:0] C_SR_HOLD = 2'b00;
    localparam logic [1:0] C_SR_LOAD = 2'b11;
    localparam logic [1:0] C_SR_SHUP = 2'b01;
    localparam logic [1:0] C_SR_SHDN = 2'b10;

    localparam logic [1:0] C_MODE_LOAD  = 2'd0;
    localparam logic [1:0] C_MODE_ROTU  = 2'd1;
    localparam logic [1:0] C_MODE_ROTD  = 2'd2;
    localparam logic [1:0] C_MODE_ZFILL = 2'd3;

endpackage : zjh_pkg
`default_nettype wire

// File: rtl/zjh_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : zjh_shift_ctrl
//  Purpose  : Sequences clear/load/shift commands into an external 74HC194.
//  Revision : 1.0 - initial release
// ============================================================================
module zjh_shift_ctrl
    import zjh_pkg::*;
(
    input  logic       Clk,
    input  logic       MR_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_data,
    input  logic [3:0] cmd_count,
    input  logic [3:0] sr_q,
    output logic       sr_mr_n,
    output logic [1:0] sr_s,
    output logic [1:0] sr_d,
    output logic [3:0] sr_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] result
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_mode;
    logic [3:0] r_data;
    logic [3:0] r_count;
    logic [3:0] r_cnt;

    logic       r_sr_mr_n;
    logic [1:0] r_sr_s;
    logic [1:0] r_sr_d;
    logic [3:0] r_sr_in;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_result;

    logic       w_sr_mr_n;
    logic [1:0] w_sr_s;
    logic [1:0] w_sr_d;
    logic [3:0] w_sr_in;
    logic       w_fb_up;
    logic       w_fb_dn;

    assign cmd_ready = (r_state == S_IDLE);

    // Serial inputs are registered, so they are predicted from the bit that
    // will sit at q[3] (up) or q[0] (down) once the current edge has shifted.
    assign w_fb_up = (r_state == S_LOAD) ? r_data[3] : sr_q[2];
    assign w_fb_dn = (r_state == S_LOAD) ? r_data[0] : sr_q[1];

    always_comb begin
        w_next    = r_state;
        w_sr_mr_n = 1'b1;
        w_sr_s    = C_SR_HOLD;
        w_sr_d    = 2'b00;
        w_sr_in   = 4'b0000;

        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = S_CLEAR;
            S_CLEAR: w_next = S_LOAD;
            S_LOAD:  w_next = (r_mode != C_MODE_LOAD && r_count != 4'd0) ? S_SHIFT : S_FIN;
            S_SHIFT: w_next = (r_cnt == 4'd1) ? S_FIN : S_SHIFT;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        case (w_next)
            S_CLEAR: w_sr_mr_n = 1'b0;
            S_LOAD: begin
                w_sr_s  = C_SR_LOAD;
                w_sr_in = r_data;
            end
            S_SHIFT: begin
                case (r_mode)
                    C_MODE_ROTU: begin
                        w_sr_s = C_SR_SHUP;
                        w_sr_d = {w_fb_up, 1'b0};
                    end
                    C_MODE_ROTD: begin
                        w_sr_s = C_SR_SHDN;
                        w_sr_d = {1'b0, w_fb_dn};
                    end
                    default: w_sr_s = C_SR_SHDN;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!MR_N) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'd0;
            r_data    <= 4'd0;
            r_count   <= 4'd0;
            r_cnt     <= 4'd0;
            r_sr_mr_n <= 1'b0;
            r_sr_s    <= C_SR_HOLD;
            r_sr_d    <= 2'b00;
            r_sr_in   <= 4'b0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= 4'b0000;
        end else begin
            r_state   <= w_next;
            r_sr_mr_n <= w_sr_mr_n;
            r_sr_s    <= w_sr_s;
            r_sr_d    <= w_sr_d;
            r_sr_in   <= w_sr_in;
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (r_state == S_FIN);
            if (r_state == S_IDLE && cmd_valid) begin
                r_mode  <= cmd_mode;
                r_data  <= cmd_data;
                r_count <= cmd_count;
            end
            if (r_state == S_LOAD)
                r_cnt <= r_count;
            else if (r_state == S_SHIFT)
                r_cnt <= r_cnt - 4'd1;
            // The last shift lands on the edge entering FIN, so capture here.
            if (r_state == S_FIN)
                r_result <= sr_q;
        end
    end

    assign sr_mr_n = r_sr_mr_n;
    assign sr_s    = r_sr_s;
    assign sr_d    = r_sr_d;
    assign sr_in   = r_sr_in;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;

endmodule : zjh_shift_ctrl
`default_nettype wire
